// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shift/rotate unit: op codes, FSM states, op legality.
// Rotate ops are legal only when SEQ_SHIFT_ROTATE_EN is defined.
package shift_pkg;

  localparam logic [2:0] OP_SRL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_illegal_op(input logic [2:0] op);
`ifdef SEQ_SHIFT_ROTATE_EN
    return (op > OP_ROL);
`else
    return (op > OP_SRA);
`endif
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational barrel shift of WIDTH bits by 0..STEP positions for one op.
// Rotate wrap logic exists only when SEQ_SHIFT_ROTATE_EN is defined.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic [2:0]                   op,
  input  logic [WIDTH-1:0]             data,
  input  logic [$clog2(STEP+1)-1:0]    amt,
  output logic [WIDTH-1:0]             result
);

`ifdef SEQ_SHIFT_ROTATE_EN
  localparam int SHW = $clog2(WIDTH);
  // Complementary distance for the wrapped half; amt == 0 gives WIDTH, which shifts everything out.
  logic [SHW:0] rev;
  assign rev = (SHW+1)'(WIDTH) - (SHW+1)'(amt);
`endif

  always_comb begin
    result = data;
    case (op)
      OP_SRL:  result = data >> amt;
      OP_SLL:  result = data << amt;
      OP_SRA:  result = $signed(data) >>> amt;
`ifdef SEQ_SHIFT_ROTATE_EN
      OP_ROR:  result = (data >> amt) | (data << rev);
      OP_ROL:  result = (data << amt) | (data >> rev);
`endif
      default: result = data;
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: at most STEP bit positions per clock, valid/ready on both sides.
// Define SEQ_SHIFT_ROTATE_EN to enable ROR/ROL; otherwise they decode as illegal (pass-through).
module seq_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             busy,
  output state_t           dbg_state
);

  // Handshake: a transfer happens on an edge where valid && ready; in_ready is high
  // only in IDLE, out_valid only in DONE, and both are decoded from state alone.

  localparam int AW = $clog2(STEP+1);
  localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);

  state_t           state_q, state_n;
  logic [WIDTH-1:0] data_q, data_n;
  logic [2:0]       op_q, op_n;
  logic [SHW-1:0]   count_q, count_n;
  logic [AW-1:0]    step_amt;
  logic [SHW-1:0]   count_dec;
  logic [WIDTH-1:0] step_out;

  assign step_amt  = ({1'b0, count_q} >= STEP_W) ? AW'(STEP) : AW'(count_q);
  assign count_dec = count_q - SHW'(step_amt);

  shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .op     (op_q),
    .data   (data_q),
    .amt    (step_amt),
    .result (step_out)
  );

  always_comb begin
    state_n = state_q;
    data_n  = data_q;
    op_n    = op_q;
    count_n = count_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_n  = in_a;
          op_n    = in_op;
          count_n = in_shamt;
          state_n = (in_shamt == '0 || is_illegal_op(in_op)) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_n  = step_out;
        count_n = count_dec;
        if (count_dec == '0) state_n = DONE;
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // kill beats everything, including an accept in IDLE: registers other than count keep their value.
    if (kill) begin
      state_n = IDLE;
      data_n  = data_q;
      op_n    = op_q;
      count_n = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      op_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_n;
      data_q  <= data_n;
      op_q    <= op_n;
      count_q <= count_n;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_result = data_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit (WIDTH=32, STEP=4) with an expected-result queue.
// Expectations follow SEQ_SHIFT_ROTATE_EN the same way the design build does.
module tb_seq_shift_unit;
  import shift_pkg::*;

  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_op = 3'b000;
  logic [W-1:0] in_a = '0;
  logic [4:0]   in_shamt = '0;
  logic         kill = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         busy;
  state_t       dbg_state;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           vectors = 0;
  int           miscompares = 0;

  seq_shift_unit #(.WIDTH(W), .STEP(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_shamt   (in_shamt),
    .kill       (kill),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  function automatic logic legal(input logic [2:0] op);
`ifdef SEQ_SHIFT_ROTATE_EN
    return op <= 3'd4;
`else
    return op <= 3'd2;
`endif
  endfunction

  // Whole-distance reference, independent of the per-step decomposition.
  function automatic logic [W-1:0] ref_shift(input logic [2:0] op, input logic [W-1:0] a,
                                             input int sh);
    logic [2*W-1:0] dbl;
    dbl = {a, a};
    if (!legal(op)) return a;
    case (op)
      3'd0: return a >> sh;
      3'd1: return a << sh;
      3'd2: return $signed(a) >>> sh;
      3'd3: return dbl[sh +: W];
      3'd4: return dbl[(W - sh) % W +: W];
      default: return a;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input int sh);
    if (!legal(op) || sh == 0) return 0;
    return (sh + S - 1) / S;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: push expectation, present request, measure latency, optionally hold out_ready low.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input int sh,
                        input int hold);
    int edges;
    logic [W-1:0] exp_r;
    int exp_l;
    exp_q.push_back(ref_shift(op, a, sh));
    lat_q.push_back(ref_lat(op, sh));
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_shamt = 5'(sh);
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 64) begin
      check("busy_while_shifting", {63'd0, busy}, 64'd1);
      @(posedge clk); #1;
      edges++;
    end
    exp_r = exp_q.pop_front();
    exp_l = lat_q.pop_front();
    check("out_valid_rose", {63'd0, out_valid}, 64'd1);
    check("latency", 64'(edges), 64'(exp_l));
    check("result", 64'(out_result), 64'(exp_r));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_result", 64'(out_result), 64'(exp_r));
      check("hold_in_ready_low", {63'd0, in_ready}, 64'd0);
      check("hold_out_valid", {63'd0, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("back_to_idle", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    // reset state
    #12;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;

    // directed cases
    run_op(3'd0, 32'h8000_0000, 9, 0);
    run_op(3'd2, 32'hF000_0000, 31, 0);
    run_op(3'd4, 32'h8000_0001, 1, 0);
    run_op(3'd1, 32'h0000_1234, 0, 5);
    run_op(3'd3, 32'h0000_00F1, 4, 0);
    run_op(3'd7, 32'hDEAD_BEEF, 13, 0);
    run_op(3'd1, 32'hFFFF_FFFF, 31, 0);

    // kill mid-shift after one step of shamt=16
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'hFFFF_0000; in_shamt = 5'd16;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("kill_pre_busy", {63'd0, busy}, 64'd1);
    @(negedge clk); kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    check("kill_idle", 64'(dbg_state), 64'(IDLE));
    check("kill_in_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("kill_no_valid", {63'd0, out_valid}, 64'd0);
    end
    run_op(3'd1, 32'h0000_0001, 4, 0);

    // kill together with in_valid in IDLE: request dropped
    @(negedge clk);
    in_valid = 1'b1; kill = 1'b1; in_op = 3'd1; in_a = 32'h5; in_shamt = 5'd3;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    check("kill_blocks_accept", {63'd0, busy}, 64'd0);

    // random stimulus
    for (int i = 0; i < 12; i++)
      run_op(3'($urandom_range(0, 7)), $urandom, int'($urandom_range(0, 31)), 0);

    // asynchronous reset during SHIFT
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'hAAAA_5555; in_shamt = 5'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    check("pre_reset_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("async_rst_result", 64'(out_result), 64'd0);
    check("async_rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    run_op(3'd2, 32'h8000_0010, 5, 0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
